// File: rtl/calc_pkg.sv
// Shared calculator definitions: operator codes, scanner states and the keypad decode table.
package calc_pkg;

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef enum logic [2:0] {SCAN, DEBOUNCE, LOAD, STROBE, RELEASE} scan_state_t;

  typedef enum logic [2:0] {DIGIT, OPER, EQUAL, CLEAR, NONE} key_kind_t;

  typedef struct packed {
    key_kind_t  kind;
    logic [3:0] val;
  } key_entry_t;

  // Indexed by {row, col}; operators carry their one-hot code in val[2:0].
  localparam key_entry_t KEY_MAP [16] = '{
    '{DIGIT, 4'd1}, '{DIGIT, 4'd2}, '{DIGIT, 4'd3}, '{OPER, {1'b0, OP_ADD}},
    '{DIGIT, 4'd4}, '{DIGIT, 4'd5}, '{DIGIT, 4'd6}, '{OPER, {1'b0, OP_SUB}},
    '{DIGIT, 4'd7}, '{DIGIT, 4'd8}, '{DIGIT, 4'd9}, '{OPER, {1'b0, OP_MUL}},
    '{CLEAR, 4'd0}, '{DIGIT, 4'd0}, '{EQUAL, 4'd0}, '{NONE, 4'd0}
  };

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, with a configurable reset value.
module sync_2ff #(
  parameter int unsigned     WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      q      <= RESET_VAL;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: column scan, row debounce, and decode into gencon's
// digit/operator/equal/clear interface.
module keypad_scanner
  import calc_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       RST,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] keypad_input,
  output logic       read_input,
  output logic [2:0] operator_input,
  output logic       equal_input,
  output logic       clear_pulse
);

  localparam int unsigned CntMax = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax);
  localparam logic [CntW-1:0] ScanLast = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] DebLast  = CntW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]      rs;
  scan_state_t     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      col_q, col_d;
  logic [1:0]      row_q, row_d;
  logic [3:0]      digit_q;
  logic [2:0]      op_q;
  logic            one_low;
  logic [1:0]      low_row;
  logic [3:0]      row_pattern;
  key_entry_t      key;
  logic            clear_now;

  sync_2ff #(
    .WIDTH     (4),
    .RESET_VAL (4'hF)
  ) u_row_sync (
    .clk (clk),
    .rst (RST),
    .d   (row_in),
    .q   (rs)
  );

  // Exactly one row low identifies a single key; anything else is treated as no key.
  always_comb begin
    one_low = 1'b1;
    low_row = 2'd0;
    unique case (rs)
      4'b1110: low_row = 2'd0;
      4'b1101: low_row = 2'd1;
      4'b1011: low_row = 2'd2;
      4'b0111: low_row = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  assign row_pattern = ~(4'b0001 << row_q);
  assign key         = KEY_MAP[{row_q, col_q}];

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q <= SCAN;
      cnt_q   <= '0;
      col_q   <= 2'd0;
      row_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    unique case (state_q)
      SCAN: begin
        if (cnt_q == ScanLast) begin
          cnt_d = '0;
          if (one_low) begin
            row_d   = low_row;
            state_d = DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (rs != row_pattern) begin
          cnt_d   = '0;
          col_d   = col_q + 2'd1;
          state_d = SCAN;
        end else if (cnt_q == DebLast) begin
          cnt_d   = '0;
          state_d = LOAD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LOAD:   state_d = STROBE;
      STROBE: state_d = RELEASE;
      RELEASE: begin
        if (rs != 4'hF) begin
          cnt_d = '0;
        end else if (cnt_q == DebLast) begin
          cnt_d   = '0;
          col_d   = col_q + 2'd1;
          state_d = SCAN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = SCAN;
      end
    endcase
  end

  // Values load on entry to LOAD so they are visible a full cycle ahead of the strobe.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      digit_q <= 4'd0;
      op_q    <= 3'd0;
    end else if (state_q == DEBOUNCE && state_d == LOAD) begin
      if (key.kind == DIGIT) digit_q <= key.val;
      if (key.kind == OPER)  op_q    <= key.val[2:0];
    end else if (clear_now) begin
      op_q <= 3'd0;
    end
  end

  assign clear_now = (state_q == STROBE) && (key.kind == CLEAR);

  always_comb begin
    col_out        = ~(4'b0001 << col_q);
    keypad_input   = digit_q;
    read_input     = (state_q == STROBE) && (key.kind == DIGIT);
    equal_input    = (state_q == STROBE) && (key.kind == EQUAL);
    clear_pulse    = clear_now;
    // Operator drops in the clear cycle itself; the register follows on the next edge.
    operator_input = clear_now ? 3'd0 : op_q;
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a matrix keypad model driving row_in from col_out.
module tb_keypad_scanner;
  import calc_pkg::*;

  logic       clk = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] keypad_input;
  logic       read_input;
  logic [2:0] operator_input;
  logic       equal_input;
  logic       clear_pulse;

  logic [15:0] pressed = 16'h0;

  int n_total = 0;
  int n_bad   = 0;
  int n_read = 0, n_eq = 0, n_clr = 0;
  int unstable = 0, overlap = 0, long_pulse = 0, clr_op_bad = 0;
  logic [3:0] last_digit = 4'd0;
  logic [3:0] prev_kin = 4'd0;
  logic       prev_read = 1'b0, prev_eq = 1'b0, prev_clr = 1'b0;

  keypad_scanner #(
    .SCAN_DIV        (4),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clk            (clk),
    .RST            (RST),
    .row_in         (row_in),
    .col_out        (col_out),
    .keypad_input   (keypad_input),
    .read_input     (read_input),
    .operator_input (operator_input),
    .equal_input    (equal_input),
    .clear_pulse    (clear_pulse)
  );

  always #5 clk = ~clk;

  // A pressed key at (r,c) pulls row r low while column c is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (!RST) begin
      if (read_input) begin
        n_read++;
        last_digit = keypad_input;
        if (prev_kin != keypad_input) unstable++;
      end
      if (equal_input) n_eq++;
      if (clear_pulse) begin
        n_clr++;
        if (operator_input != 3'd0) clr_op_bad++;
      end
      if (int'(read_input) + int'(equal_input) + int'(clear_pulse) > 1) overlap++;
      if ((read_input && prev_read) || (equal_input && prev_eq) || (clear_pulse && prev_clr))
        long_pulse++;
    end
    prev_kin  = keypad_input;
    prev_read = read_input;
    prev_eq   = equal_input;
    prev_clr  = clear_pulse;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tap(input int r, input int c);
    pressed[r*4+c] = 1'b1;
    repeat (100) @(negedge clk);
    pressed = 16'h0;
    repeat (40) @(negedge clk);
  endtask

  int         base_read, base_eq, base_clr;
  logic [3:0] c0;
  logic       found;
  logic [3:0] rot [4];

  initial begin
    rot[0] = 4'b1101; rot[1] = 4'b1011; rot[2] = 4'b0111; rot[3] = 4'b1110;

    repeat (3) @(negedge clk);
    check("rst_col", col_out, 4'b1110);
    check("rst_kin", keypad_input, 4'd0);
    check("rst_pulses", {read_input, equal_input, clear_pulse}, 3'b000);
    check("rst_op", operator_input, 3'd0);
    RST = 1'b0;

    // Single '2' press with release.
    base_read = n_read;
    tap(0, 1);
    check("two_strobes", n_read - base_read, 1);
    check("two_digit", last_digit, 4'd2);
    check("two_kin", keypad_input, 4'd2);
    check("two_stable", unstable, 0);
    check("two_state", int'(dut.state_q), int'(SCAN));
    c0 = col_out;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (col_out != c0) found = 1'b1;
    end
    check("two_rescan", found, 1'b1);

    // 12 + 34 = sequence.
    base_read = n_read; base_eq = n_eq;
    tap(0, 0);
    tap(0, 1);
    tap(0, 3);
    check("seq_op_add", operator_input, OP_ADD);
    tap(0, 2);
    tap(1, 0);
    check("seq_kin4", keypad_input, 4'd4);
    tap(3, 2);
    check("seq_digits", n_read - base_read, 4);
    check("seq_equal", n_eq - base_eq, 1);
    check("seq_op_held", operator_input, OP_ADD);

    // Bouncing '5' never settles.
    base_read = n_read; base_eq = n_eq;
    for (int i = 0; i < 3; i++) begin
      pressed[5] = 1'b1;
      repeat (3) @(negedge clk);
      pressed[5] = 1'b0;
      repeat (3) @(negedge clk);
    end
    repeat (40) @(negedge clk);
    check("bounce_read", n_read - base_read, 0);
    check("bounce_eq", n_eq - base_eq, 0);
    check("bounce_op", operator_input, OP_ADD);
    check("bounce_state", int'(dut.state_q), int'(SCAN));

    // Operator replacement and clear.
    base_clr = n_clr;
    tap(1, 3);
    check("op_sub", operator_input, OP_SUB);
    tap(2, 3);
    check("op_mul", operator_input, OP_MUL);
    tap(3, 0);
    check("op_cleared", operator_input, 3'd0);
    check("clr_count", n_clr - base_clr, 1);
    check("clr_op_in_pulse", clr_op_bad, 0);

    // Two rows low on column 0: no key, scan keeps rotating.
    base_read = n_read; base_eq = n_eq; base_clr = n_clr;
    pressed[0] = 1'b1;
    pressed[4] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (col_out == 4'b1110) found = 1'b1;
    end
    check("multi_find_c0", found, 1'b1);
    for (int k = 0; k < 4; k++) begin
      c0 = col_out;
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
        @(negedge clk);
        if (col_out != c0) found = 1'b1;
      end
      check("multi_rot", col_out, rot[k]);
    end
    repeat (30) @(negedge clk);
    pressed = 16'h0;
    repeat (20) @(negedge clk);
    check("multi_events", (n_read - base_read) + (n_eq - base_eq) + (n_clr - base_clr), 0);

    // Reset while debouncing '7'.
    tap(0, 3);
    check("pre_rst_op", operator_input, OP_ADD);
    base_read = n_read;
    pressed[8] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (dut.state_q == DEBOUNCE) found = 1'b1;
    end
    check("rst_reach_deb", found, 1'b1);
    RST = 1'b1;
    #1;
    check("mid_rst_col", col_out, 4'b1110);
    check("mid_rst_kin", keypad_input, 4'd0);
    check("mid_rst_op", operator_input, 3'd0);
    check("mid_rst_state", int'(dut.state_q), int'(SCAN));
    pressed = 16'h0;
    repeat (3) @(negedge clk);
    RST = 1'b0;
    repeat (40) @(negedge clk);
    check("post_rst_read", n_read - base_read, 0);
    check("post_rst_kin", keypad_input, 4'd0);
    tap(2, 0);
    check("seven_strobes", n_read - base_read, 1);
    check("seven_kin", keypad_input, 4'd7);

    check("no_overlap", overlap, 0);
    check("pulse_width", long_pulse, 0);
    check("kin_stable", unstable, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
